// File: rtl/dht11_scheduler.sv
// DHT11 measurement sequencer: merges host read commands and a periodic
// auto-trigger into single sensor transactions, keeps start pulses at least
// MIN_GAP_CYCLES apart, validates the frame checksum, retries failed attempts
// and hands one 16-bit result per transaction to the UART side.
module dht11_scheduler #(
  parameter int unsigned MIN_GAP_CYCLES = 100_000_000,
  parameter int unsigned PERIOD_CYCLES  = 200_000_000,
  parameter int unsigned MEAS_TIMEOUT   = 10_000_000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        auto_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        meas_start,
  input  logic        meas_done,
  input  logic        meas_err,
  input  logic [39:0] meas_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [1:0]  res_status,
  output logic        res_src,
  output logic        busy
);

  localparam int GW = (MIN_GAP_CYCLES < 1) ? 1 : $clog2(MIN_GAP_CYCLES + 1);
  localparam int PW = (PERIOD_CYCLES < 2) ? 1 : $clog2(PERIOD_CYCLES);
  localparam int TW = (MEAS_TIMEOUT < 2) ? 1 : $clog2(MEAS_TIMEOUT);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_GAP_CYCLES);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(MEAS_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_CSUM = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, GAP, START, WAIT, CHECK, FAIL, REPORT
  } state_t;

  state_t          state;
  logic            pending_cmd;
  logic            pending_auto;
  logic            cur_src;
  logic [RW-1:0]   retry_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [PW-1:0]   per_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [39:0]     frame;
  logic            frame_err;
  logic [1:0]      fail_st;

  logic            take_cmd;
  logic            per_wrap;
  logic            clr_pend;
  logic            gap_ok;
  logic [7:0]      csum;

  // Ready is held low through reset so every output reads 0 while rst_n=0.
  assign cmd_ready = rst_n & ~pending_cmd;
  assign take_cmd  = cmd_valid & cmd_ready;
  assign per_wrap  = auto_en && (per_cnt == PER_LAST);
  // Pending requests are consumed only by the first attempt of a transaction;
  // retries belong to the same transaction.
  assign clr_pend  = (state == START) && (retry_cnt == '0);
  assign gap_ok    = (gap_cnt == GAP_MAX);
  assign csum      = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];

  // Free-running auto-trigger period counter, held at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           per_cnt <= '0;
    else if (!auto_en)    per_cnt <= '0;
    else if (per_wrap)    per_cnt <= '0;
    else                  per_cnt <= per_cnt + PW'(1);
  end

  // One-deep request latches per source; a new request wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_cmd  <= 1'b0;
      pending_auto <= 1'b0;
    end else begin
      pending_cmd  <= take_cmd | (pending_cmd & ~clr_pend);
      pending_auto <= per_wrap | (pending_auto & ~clr_pend);
    end
  end

  // Cycles since the last start pulse, saturating once the gap is satisfied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          gap_cnt <= '0;
    else if (meas_start) gap_cnt <= '0;
    else if (!gap_ok)    gap_cnt <= gap_cnt + GW'(1);
  end

  // Transaction sequencer with registered start/result/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      meas_start <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_status <= '0;
      res_src    <= 1'b0;
      cur_src    <= 1'b0;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      frame      <= '0;
      frame_err  <= 1'b0;
      fail_st    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending_cmd | pending_auto) begin
            busy <= 1'b1;
            if (gap_ok) begin
              state      <= START;
              meas_start <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_ok) begin
            state      <= START;
            meas_start <= 1'b1;
          end
        end
        START: begin
          meas_start <= 1'b0;
          tmo_cnt    <= '0;
          state      <= WAIT;
          if (retry_cnt == '0) cur_src <= pending_cmd;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still counts as a response.
          if (meas_done) begin
            frame     <= meas_data;
            frame_err <= meas_err;
            state     <= CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            fail_st <= ST_TMO;
            state   <= FAIL;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        CHECK: begin
          if (frame_err) begin
            fail_st <= ST_TMO;
            state   <= FAIL;
          end else if (csum != frame[7:0]) begin
            fail_st <= ST_CSUM;
            state   <= FAIL;
          end else begin
            res_data   <= {frame[23:16], frame[39:32]};
            res_status <= ST_OK;
            res_src    <= cur_src;
            state      <= REPORT;
          end
        end
        FAIL: begin
          if (retry_cnt < RETRY_MAX) begin
            retry_cnt <= retry_cnt + RW'(1);
            state     <= GAP;
          end else begin
            res_data   <= '0;
            res_status <= fail_st;
            res_src    <= cur_src;
            state      <= REPORT;
          end
        end
        REPORT: begin
          // Payload is loaded on entry; valid follows one cycle later so the
          // handshake only ever sees a fully registered result.
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            retry_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_scheduler.sv
// Directed bench for dht11_scheduler: a sensor model answers start pulses from
// a plan queue, a result model derives expected results from the frame rules,
// and a single monitor checks gap, pulse width, result stability and payloads.
module tb_dht11_scheduler;

  localparam int MIN_GAP   = 20;
  localparam int PERIOD    = 100;
  localparam int TMO       = 50;
  localparam int MAX_RETRY = 2;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  st;
    logic        src;
  } res_t;

  typedef struct {
    int          dly;
    logic [39:0] data;
    bit          err;
    bit          nd;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        auto_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        meas_start;
  logic        meas_done;
  logic        meas_err;
  logic [39:0] meas_data;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_status;
  logic        res_src;
  logic        busy;

  int   nvec;
  int   nerr;
  int   cyc;
  int   n_starts;
  int   start_cyc[$];
  rsp_t plan_q[$];
  res_t exp_q[$];

  dht11_scheduler #(
    .MIN_GAP_CYCLES(MIN_GAP),
    .PERIOD_CYCLES (PERIOD),
    .MEAS_TIMEOUT  (TMO),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .auto_en   (auto_en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .meas_start(meas_start),
    .meas_done (meas_done),
    .meas_err  (meas_err),
    .meas_data (meas_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_status(res_status),
    .res_src   (res_src),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit csum_ok(input logic [39:0] d);
    int s;
    s = int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]);
    return (s % 256) == int'(d[7:0]);
  endfunction

  // Transaction outcome from the frame rules: first good frame wins, otherwise
  // a zero result carrying the status of the last failed attempt.
  function automatic res_t model(input rsp_t a, input rsp_t b, input rsp_t c, input logic src);
    rsp_t       p[3];
    logic [1:0] st;
    p[0] = a; p[1] = b; p[2] = c;
    st = 2'b10;
    for (int i = 0; i <= MAX_RETRY; i++) begin
      if (p[i].nd || p[i].err) st = 2'b10;
      else if (csum_ok(p[i].data)) return res_t'{{p[i].data[23:16], p[i].data[39:32]}, 2'b00, src};
      else st = 2'b01;
    end
    return res_t'{16'h0000, st, src};
  endfunction

  function automatic rsp_t mk(input int dly, input logic [39:0] d, input bit err, input bit nd);
    rsp_t r;
    r.dly = dly; r.data = d; r.err = err; r.nd = nd;
    return r;
  endfunction

  // Sensor frontend model: one planned response per start pulse.
  initial begin
    rsp_t p;
    meas_done = 1'b0;
    meas_err  = 1'b0;
    meas_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && meas_start && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        if (!p.nd) begin
          repeat (p.dly) @(negedge clk);
          meas_done = 1'b1;
          meas_err  = p.err;
          meas_data = p.data;
          @(negedge clk);
          meas_done = 1'b0;
          meas_err  = 1'b0;
        end
      end
    end
  end

  // Monitor: start spacing and width, result stability, result payloads.
  initial begin
    res_t cur;
    res_t prev;
    bit   hold;
    bit   prev_start;
    int   last;
    hold = 0; prev_start = 0; last = 0; prev = '0;
    forever begin
      @(negedge clk);
      #1;
      cur = res_t'{res_data, res_status, res_src};
      if (!rst_n) begin
        hold = 0;
        prev_start = 0;
        last = cyc;
      end else begin
        if (meas_start) begin
          chk("start_one_cycle", prev_start, 0);
          if (!prev_start) begin
            chk("start_gap", (cyc - last) >= MIN_GAP, 1);
            last = cyc;
            n_starts++;
            start_cyc.push_back(cyc);
          end
        end
        if (hold) begin
          chk("hold_valid", res_valid, 1);
          chk("hold_payload", cur, prev);
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_result: got %0h, expected none", cur);
          end else begin
            chk("result", cur, exp_q.pop_front());
          end
        end
        hold = res_valid && !res_ready;
        prev_start = meas_start;
        prev = cur;
      end
    end
  end

  task automatic send_cmd();
    @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_sig(input string nm, input bit want_start, input int budget, output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(want_start ? meas_start : res_valid) && n < budget);
    t = cyc;
    chk(nm, n < budget, 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, n < budget, 1);
  endtask

  task automatic run_model(input string nm, input rsp_t a, input rsp_t b, input rsp_t c, input int n);
    int   s0;
    rsp_t p[3];
    p[0] = a; p[1] = b; p[2] = c;
    s0 = n_starts;
    for (int i = 0; i < n; i++) plan_q.push_back(p[i]);
    exp_q.push_back(model(a, b, c, 1'b1));
    send_cmd();
    wait_idle({nm, "_idle"}, 400);
    chk({nm, "_starts"}, n_starts - s0, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, t, t2, s0, s1, k, b;
    rsp_t good, bad50, bad, nod, errf;
    good  = mk(5, 40'h37001A0051, 0, 0);
    bad50 = mk(5, 40'h37001A0050, 0, 0);
    bad   = mk(5, 40'h1020304000, 0, 0);
    nod   = mk(0, 40'h0, 0, 1);
    errf  = mk(5, 40'h37001A0051, 1, 0);

    rst_n = 1'b0; auto_en = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_meas_start", meas_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_res_payload", {res_data, res_status, res_src}, 0);

    // Basic command at cycle 3 after release
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    plan_q.push_back(good);
    exp_q.push_back(res_t'{16'h1A37, 2'b00, 1'b1});
    s0 = n_starts;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("cmd_ready_pending", cmd_ready, 0);
    wait_sig("basic_start_seen", 1, 60, t);
    chk("basic_first_start", t - rel, 21);
    wait_sig("basic_res_seen", 0, 30, t2);
    chk("basic_res_latency", t2 - t, 8);
    wait_idle("basic_idle", 100);
    chk("basic_starts", n_starts - s0, 1);
    chk("basic_busy", busy, 0);

    // Checksum retry: two bad frames then a good one
    s0 = n_starts;
    plan_q.push_back(bad50);
    plan_q.push_back(bad50);
    plan_q.push_back(good);
    exp_q.push_back(res_t'{16'h1A37, 2'b00, 1'b1});
    send_cmd();
    wait_idle("retry_idle", 400);
    chk("retry_starts", n_starts - s0, 3);

    // No response on any attempt
    s0 = n_starts;
    repeat (3) plan_q.push_back(nod);
    exp_q.push_back(res_t'{16'h0000, 2'b10, 1'b1});
    send_cmd();
    wait_idle("noresp_idle", 400);
    chk("noresp_starts", n_starts - s0, 3);
    k = start_cyc.size();
    chk("noresp_spacing1", start_cyc[k-2] - start_cyc[k-3], 53);
    chk("noresp_spacing2", start_cyc[k-1] - start_cyc[k-2], 53);

    // Model-derived cases: error/bad/good, all failures, checksum wraparound
    run_model("m_err_bad_good", errf, bad, mk(5, 40'h2D0517034C, 0, 0), 3);
    run_model("m_err_bad_bad", errf, bad, bad, 3);
    run_model("m_wrap", mk(3, 40'hFFFFFFFFFC, 0, 0), nod, nod, 1);

    // Auto trigger with result backpressure
    s0 = n_starts;
    res_ready = 1'b0;
    plan_q.push_back(good);
    plan_q.push_back(good);
    exp_q.push_back(res_t'{16'h1A37, 2'b00, 1'b0});
    exp_q.push_back(res_t'{16'h1A37, 2'b00, 1'b0});
    @(negedge clk);
    auto_en = 1'b1;
    wait_sig("auto_res_seen", 0, 300, t);
    repeat (150) @(negedge clk);
    #1;
    chk("auto_held_valid", res_valid, 1);
    auto_en = 1'b0;
    res_ready = 1'b1;
    wait_idle("auto_idle", 300);
    repeat (250) @(negedge clk);
    #1;
    chk("auto_starts", n_starts - s0, 2);

    // Command and period wrap on the same edge
    repeat (30) @(negedge clk);
    s0 = n_starts;
    plan_q.push_back(good);
    exp_q.push_back(res_t'{16'h1A37, 2'b00, 1'b1});
    @(negedge clk);
    auto_en = 1'b1;
    b = cyc;
    repeat (99) @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    auto_en = 1'b0;
    #1;
    chk("sim_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("sim_start_now", meas_start, 1);
    chk("sim_start_cycle", cyc - b, 101);
    chk("sim_cmd_ready_start", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("sim_cmd_ready_back", cmd_ready, 1);
    wait_idle("sim_idle", 200);
    repeat (150) @(negedge clk);
    #1;
    chk("sim_starts", n_starts - s0, 1);

    // Reset while waiting for the frame; the late done must be ignored
    plan_q.push_back(mk(40, 40'h37001A0051, 0, 0));
    send_cmd();
    wait_sig("rstw_start_seen", 1, 60, t);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_meas_start", meas_start, 0);
    chk("rstw_res_valid", res_valid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_cmd_ready", cmd_ready, 0);
    chk("rstw_payload", {res_data, res_status, res_src}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s1 = n_starts;
    repeat (150) @(negedge clk);
    #1;
    chk("rstw_no_start", n_starts - s1, 0);
    chk("rstw_busy_after", busy, 0);
    chk("rstw_no_result", res_valid, 0);
    chk("plan_drained", plan_q.size(), 0);
    chk("exp_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
